// File: rtl/seg7_pkg.sv
// Shared segment patterns and nibble encoder for the 7-segment scan driver.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111101;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1101111;
  localparam logic [6:0] SEG_A   = 7'b1110111;
  localparam logic [6:0] SEG_B   = 7'b1111100;
  localparam logic [6:0] SEG_C   = 7'b0111001;
  localparam logic [6:0] SEG_D   = 7'b1011110;
  localparam logic [6:0] SEG_E   = 7'b1111001;
  localparam logic [6:0] SEG_F   = 7'b1110001;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Letters only appear in hex mode; otherwise 10..15 are dark.
  function automatic logic [6:0] seg7_encode(
    input logic [3:0] nibble,
    input logic       hex_mode
  );
    logic [6:0] p;
    unique case (nibble)
      4'h0: p = SEG_0;
      4'h1: p = SEG_1;
      4'h2: p = SEG_2;
      4'h3: p = SEG_3;
      4'h4: p = SEG_4;
      4'h5: p = SEG_5;
      4'h6: p = SEG_6;
      4'h7: p = SEG_7;
      4'h8: p = SEG_8;
      4'h9: p = SEG_9;
      4'hA: p = hex_mode ? SEG_A : SEG_OFF;
      4'hB: p = hex_mode ? SEG_B : SEG_OFF;
      4'hC: p = hex_mode ? SEG_C : SEG_OFF;
      4'hD: p = hex_mode ? SEG_D : SEG_OFF;
      4'hE: p = hex_mode ? SEG_E : SEG_OFF;
      4'hF: p = hex_mode ? SEG_F : SEG_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Combinational nibble -> active-high segment pattern.
// Ports: nibble (4b value), hex_mode (show A..F), seg (gfedcba, active-high).
module seg7_encoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] seg
);

  assign seg = seg7_encode(nibble, hex_mode);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver: double-buffered, lz-blanking, blink, dp.
// Ports: clk, rst (async high), en, load, data/dp/blink_mask, hex_mode,
//        blank_lz in; seg, dp_n, an (registered), frame_tick, busy out.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick,
  output logic                  busy
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic [6:0]        SEG_DARK = {7{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_DARK  = {DIGITS{ACTIVE_LOW}};

  logic [PW-1:0]       presc, presc_nx;
  logic [IW-1:0]       idx, idx_nx;
  logic [FW-1:0]       frame_cnt, frame_nx;
  logic                hidden, hidden_nx;
  logic                step, wrap, xfer;

  logic [4*DIGITS-1:0] sh_data, disp_data, disp_data_nx;
  logic [DIGITS-1:0]   sh_dp, disp_dp, disp_dp_nx;
  logic [DIGITS-1:0]   sh_mask, disp_mask, disp_mask_nx;
  logic                pending;

  logic [3:0]          nib;
  logic                sel_dp, sel_mask, sel_lz, zeros, hide;
  logic [DIGITS-1:0]   an_on;
  logic [6:0]          enc_seg, seg_lit;
  logic                dp_lit;

  assign step = en && (presc == PRESC_LAST);
  assign wrap = step && (idx == IDX_LAST);
  assign xfer = wrap && pending;
  assign busy = pending;

  always_comb begin
    presc_nx = presc;
    if (step)
      presc_nx = '0;
    else if (en)
      presc_nx = presc + 1'b1;

    idx_nx = idx;
    if (wrap)
      idx_nx = '0;
    else if (step)
      idx_nx = idx + 1'b1;

    frame_nx  = frame_cnt;
    hidden_nx = hidden;
    if (wrap) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_nx  = '0;
        hidden_nx = ~hidden;
      end else begin
        frame_nx = frame_cnt + 1'b1;
      end
    end
  end

  // Display regs only move at a frame boundary, so a frame never tears.
  assign disp_data_nx = xfer ? sh_data : disp_data;
  assign disp_dp_nx   = xfer ? sh_dp   : disp_dp;
  assign disp_mask_nx = xfer ? sh_mask : disp_mask;

  // Outputs are built from post-edge state so they move with the index.
  // Walking from the top digit down tracks "all higher nibbles are zero".
  always_comb begin
    nib      = '0;
    sel_dp   = 1'b0;
    sel_mask = 1'b0;
    sel_lz   = 1'b0;
    an_on    = '0;
    zeros    = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zeros = zeros && (disp_data_nx[4*i +: 4] == 4'h0);
      if (idx_nx == IW'(i)) begin
        nib      = disp_data_nx[4*i +: 4];
        sel_dp   = disp_dp_nx[i];
        sel_mask = disp_mask_nx[i];
        sel_lz   = blank_lz && zeros && (i > 0);
        an_on[i] = 1'b1;
      end
    end
  end

  seg7_encoder u_enc (
    .nibble   (nib),
    .hex_mode (hex_mode),
    .seg      (enc_seg)
  );

  assign hide    = sel_lz || (hidden_nx && sel_mask);
  assign seg_lit = hide ? SEG_OFF : enc_seg;
  assign dp_lit  = sel_dp && !hide;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      hidden    <= 1'b0;
      sh_data   <= '0;
      sh_dp     <= '0;
      sh_mask   <= '0;
      pending   <= 1'b0;
      disp_data <= '0;
      disp_dp   <= '0;
      disp_mask <= '0;
    end else begin
      presc     <= presc_nx;
      idx       <= idx_nx;
      frame_cnt <= frame_nx;
      hidden    <= hidden_nx;
      disp_data <= disp_data_nx;
      disp_dp   <= disp_dp_nx;
      disp_mask <= disp_mask_nx;
      // A load on the boundary edge wins: it stays pending for next frame.
      if (load) begin
        sh_data <= data;
        sh_dp   <= dp;
        sh_mask <= blink_mask;
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_DARK;
      an         <= AN_DARK;
      dp_n       <= ACTIVE_LOW;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (en) begin
        seg  <= seg_lit ^ SEG_DARK;
        an   <= an_on ^ AN_DARK;
        dp_n <= dp_lit ^ ACTIVE_LOW;
      end else begin
        seg  <= SEG_DARK;
        an   <= AN_DARK;
        dp_n <= ACTIVE_LOW;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, div 4, blink 2, low).
// Reference model works from an enabled-cycle count rather than counters.
module tb_seg7_scan_driver;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = DIGITS * SCAN_DIV;

  localparam logic [6:0] PAT [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  logic        clk = 1'b0;
  logic        rst, en, load, hex_mode, blank_lz;
  logic [15:0] data;
  logic [3:0]  dp, blink_mask;
  logic [6:0]  seg;
  logic        dp_n, frame_tick, busy;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_bad = 0;

  int          t;
  logic [15:0] m_sh_data, m_disp_data;
  logic [3:0]  m_sh_dp, m_disp_dp, m_sh_mask, m_disp_mask;
  logic        m_pend;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_dp_n, exp_ft, exp_busy;

  seg7_scan_driver #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .data       (data),
    .dp         (dp),
    .blink_mask (blink_mask),
    .hex_mode   (hex_mode),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp_n       (dp_n),
    .an         (an),
    .frame_tick (frame_tick),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    t           = 0;
    m_sh_data   = '0;
    m_sh_dp     = '0;
    m_sh_mask   = '0;
    m_disp_data = '0;
    m_disp_dp   = '0;
    m_disp_mask = '0;
    m_pend      = 1'b0;
    exp_seg     = 7'h7F;
    exp_an      = 4'hF;
    exp_dp_n    = 1'b1;
    exp_ft      = 1'b0;
    exp_busy    = 1'b0;
  endtask

  // Advance the model over one edge, clock the DUT, settle past the edge.
  task automatic step();
    bit         bnd;
    bit         blank;
    int         idx;
    logic [3:0] nib;
    logic [6:0] pat;
    bnd = 1'b0;
    if (en) begin
      t++;
      bnd = (t % FRAME) == 0;
    end
    if (bnd && m_pend) begin
      m_disp_data = m_sh_data;
      m_disp_dp   = m_sh_dp;
      m_disp_mask = m_sh_mask;
    end
    if (load) begin
      m_sh_data = data;
      m_sh_dp   = dp;
      m_sh_mask = blink_mask;
      m_pend    = 1'b1;
    end else if (bnd) begin
      m_pend = 1'b0;
    end
    exp_busy = m_pend;
    exp_ft   = bnd;
    if (!en) begin
      exp_seg  = 7'h7F;
      exp_an   = 4'hF;
      exp_dp_n = 1'b1;
    end else begin
      idx   = (t / SCAN_DIV) % DIGITS;
      nib   = m_disp_data[4*idx +: 4];
      blank = 1'b0;
      if (blank_lz && idx > 0 && (m_disp_data >> (4 * idx)) == 16'h0)
        blank = 1'b1;
      if ((((t / FRAME) / BLINK_FRAMES) % 2 == 1) && m_disp_mask[idx])
        blank = 1'b1;
      pat = (nib < 4'd10 || hex_mode) ? PAT[nib] : 7'h00;
      if (blank)
        pat = 7'h00;
      exp_seg  = ~pat;
      exp_an   = ~(4'b0001 << idx);
      exp_dp_n = !(m_disp_dp[idx] && !blank);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; data = '0; dp = '0;
    blink_mask = '0; hex_mode = 1'b0; blank_lz = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({seg, an, dp_n, frame_tick, busy} !== {7'h7F, 4'hF, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset got seg=%b an=%b dp_n=%b ft=%b busy=%b need all-off, ft=0 busy=0",
               seg, an, dp_n, frame_tick, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [6:0] ref_seg;
    int         last_tick;
    bit         seen;
    en = 1'b1; data = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    last_tick = -1;
    seen      = 1'b0;
    repeat (4 * FRAME) begin
      n_cmp++;
      if ({seg, an, dp_n, frame_tick, busy} !== {exp_seg, exp_an, exp_dp_n, exp_ft, exp_busy}) begin
        n_bad++;
        $display("FAIL scan t=%0d got %b %b %b %b %b need %b %b %b %b %b", t,
                 seg, an, dp_n, frame_tick, busy, exp_seg, exp_an, exp_dp_n, exp_ft, exp_busy);
      end
      if (frame_tick) begin
        if (last_tick >= 0) begin
          n_cmp++;
          if (t - last_tick != FRAME) begin
            n_bad++;
            $display("FAIL tick_period got %0d need %0d", t - last_tick, FRAME);
          end
        end
        last_tick = t;
        seen      = 1'b1;
      end
      if (seen) begin
        case (an)
          4'b1110: ref_seg = 7'b0011001;
          4'b1101: ref_seg = 7'b0110000;
          4'b1011: ref_seg = 7'b0100100;
          default: ref_seg = 7'b1111001;
        endcase
        n_cmp++;
        if (seg !== ref_seg) begin
          n_bad++;
          $display("FAIL scan_table an=%b got seg=%b need %b", an, seg, ref_seg);
        end
      end
      step();
    end
  endtask

  task automatic test_lz_hex();
    data = 16'h00A5; load = 1'b1; blank_lz = 1'b1; hex_mode = 1'b0;
    step();
    load = 1'b0;
    repeat (4 * FRAME) begin
      if (t % (2 * FRAME) == 0)
        hex_mode = ~hex_mode;
      step();
      n_cmp++;
      if ({seg, an, dp_n, frame_tick, busy} !== {exp_seg, exp_an, exp_dp_n, exp_ft, exp_busy}) begin
        n_bad++;
        $display("FAIL lz_hex t=%0d got %b %b %b %b %b need %b %b %b %b %b", t,
                 seg, an, dp_n, frame_tick, busy, exp_seg, exp_an, exp_dp_n, exp_ft, exp_busy);
      end
      if (!busy && an == 4'b1101 && hex_mode) begin
        n_cmp++;
        if (seg !== 7'b0001000) begin
          n_bad++;
          $display("FAIL hex_a got seg=%b need 0001000", seg);
        end
      end
      if (!busy && an == 4'b1110) begin
        n_cmp++;
        if (seg !== 7'b0010010) begin
          n_bad++;
          $display("FAIL digit5 got seg=%b need 0010010", seg);
        end
      end
    end
    blank_lz = 1'b0; hex_mode = 1'b0;
  endtask

  task automatic test_double_buffer();
    while (t % FRAME != 6) step();
    data = 16'h1111; load = 1'b1;
    step();
    load = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_set got %b need 1", busy);
    end
    while (t % FRAME != FRAME - 1) begin
      step();
      n_cmp++;
      if ({seg, an, dp_n, frame_tick, busy} !== {exp_seg, exp_an, exp_dp_n, exp_ft, exp_busy}) begin
        n_bad++;
        $display("FAIL no_tear t=%0d got %b %b %b %b %b need %b %b %b %b %b", t,
                 seg, an, dp_n, frame_tick, busy, exp_seg, exp_an, exp_dp_n, exp_ft, exp_busy);
      end
    end
    data = 16'h2222; load = 1'b1;
    step();
    load = 1'b0;
    n_cmp++;
    if ({frame_tick, busy, seg} !== {1'b1, 1'b1, 7'b1111001}) begin
      n_bad++;
      $display("FAIL load_on_wrap got ft=%b busy=%b seg=%b need 1 1 1111001",
               frame_tick, busy, seg);
    end
    repeat (2 * FRAME) begin
      step();
      n_cmp++;
      if ({seg, an, dp_n, frame_tick, busy} !== {exp_seg, exp_an, exp_dp_n, exp_ft, exp_busy}) begin
        n_bad++;
        $display("FAIL deferred t=%0d got %b %b %b %b %b need %b %b %b %b %b", t,
                 seg, an, dp_n, frame_tick, busy, exp_seg, exp_an, exp_dp_n, exp_ft, exp_busy);
      end
    end
  endtask

  task automatic test_blink();
    data = 16'h1234; dp = 4'b0100; blink_mask = 4'b0001; load = 1'b1;
    step();
    load = 1'b0;
    repeat (9 * FRAME) begin
      step();
      n_cmp++;
      if ({seg, an, dp_n, frame_tick, busy} !== {exp_seg, exp_an, exp_dp_n, exp_ft, exp_busy}) begin
        n_bad++;
        $display("FAIL blink t=%0d got %b %b %b %b %b need %b %b %b %b %b", t,
                 seg, an, dp_n, frame_tick, busy, exp_seg, exp_an, exp_dp_n, exp_ft, exp_busy);
      end
      if (!busy) begin
        n_cmp++;
        if (dp_n !== (an != 4'b1011)) begin
          n_bad++;
          $display("FAIL dp_digit an=%b got dp_n=%b need %b", an, dp_n, an != 4'b1011);
        end
      end
    end
  endtask

  task automatic test_enable();
    while (t % SCAN_DIV != 1) step();
    en = 1'b0;
    repeat (10) begin
      step();
      n_cmp++;
      if ({seg, an, dp_n, frame_tick} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL en_off got seg=%b an=%b dp_n=%b ft=%b need 1111111 1111 1 0",
                 seg, an, dp_n, frame_tick);
      end
    end
    en = 1'b1;
    repeat (2 * FRAME) begin
      step();
      n_cmp++;
      if ({seg, an, dp_n, frame_tick, busy} !== {exp_seg, exp_an, exp_dp_n, exp_ft, exp_busy}) begin
        n_bad++;
        $display("FAIL resume t=%0d got %b %b %b %b %b need %b %b %b %b %b", t,
                 seg, an, dp_n, frame_tick, busy, exp_seg, exp_an, exp_dp_n, exp_ft, exp_busy);
      end
    end
  endtask

  task automatic test_random();
    repeat (800) begin
      en       = ($urandom_range(0, 7) != 0);
      load     = ($urandom_range(0, 9) == 0);
      hex_mode = ($urandom_range(0, 15) == 0) ? ~hex_mode : hex_mode;
      blank_lz = ($urandom_range(0, 15) == 0) ? ~blank_lz : blank_lz;
      if (load) begin
        data       = 16'($urandom);
        dp         = 4'($urandom);
        blink_mask = 4'($urandom);
        if ($urandom_range(0, 2) == 0)
          data[15:8] = 8'h00;
      end
      step();
      n_cmp++;
      if ({seg, an, dp_n, frame_tick, busy} !== {exp_seg, exp_an, exp_dp_n, exp_ft, exp_busy}) begin
        n_bad++;
        $display("FAIL random t=%0d got %b %b %b %b %b need %b %b %b %b %b", t,
                 seg, an, dp_n, frame_tick, busy, exp_seg, exp_an, exp_dp_n, exp_ft, exp_busy);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    en = 1'b1; hex_mode = 1'b0; blank_lz = 1'b1;
    while (t % FRAME != 5) step();
    data = 16'h9876; dp = 4'hF; blink_mask = 4'h0; load = 1'b1;
    step();
    load = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_busy got %b need 1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({seg, an, dp_n, frame_tick, busy} !== {7'h7F, 4'hF, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset got %b %b %b %b %b need 1111111 1111 1 0 0",
               seg, an, dp_n, frame_tick, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (3 * FRAME) begin
      step();
      n_cmp++;
      if ({seg, an, dp_n, frame_tick, busy} !== {exp_seg, exp_an, exp_dp_n, exp_ft, exp_busy}) begin
        n_bad++;
        $display("FAIL post_reset t=%0d got %b %b %b %b %b need %b %b %b %b %b", t,
                 seg, an, dp_n, frame_tick, busy, exp_seg, exp_an, exp_dp_n, exp_ft, exp_busy);
      end
      n_cmp++;
      if (seg !== ((an == 4'b1110) ? 7'b1000000 : 7'h7F)) begin
        n_bad++;
        $display("FAIL zero_display an=%b got seg=%b", an, seg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz_hex();
    test_double_buffer();
    test_blink();
    test_enable();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
